// File: rtl/procyon_biu_line_fetch_pkg.sv
// Shared definitions for the BIU line-fill engine: FSM encodings and
// beat-counter sizing helpers.
package procyon_biu_pkg;

  localparam int BIU_STATE_WIDTH = 2;

  typedef enum logic [BIU_STATE_WIDTH-1:0] {
    BIU_STATE_IDLE = 2'b00,
    BIU_STATE_BUSY = 2'b01,
    BIU_STATE_DONE = 2'b10
  } biu_state_e;

  // Counter width for a given beat count, never narrower than one bit.
  function automatic int biu_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Number of low address bits selecting a byte inside one bus beat.
  function automatic int biu_byte_sel_width(input int bus_data_width);
    return $clog2(bus_data_width / 8);
  endfunction

endpackage

// File: rtl/procyon_biu_line_fetch_if.sv
// MHQ request/completion and memory-bus signals of the line-fill engine.
// The slave modport is the engine itself; master is the MHQ plus memory side.
interface procyon_biu_line_fetch_if #(
  parameter int OPTN_ADDR_WIDTH     = 32,
  parameter int OPTN_DC_LINE_SIZE   = 32,
  parameter int OPTN_BUS_DATA_WIDTH = 32,
  parameter int OPTN_MHQ_TAG_WIDTH  = 2
);
  localparam int DC_LINE_WIDTH   = OPTN_DC_LINE_SIZE * 8;
  localparam int DC_OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE);

  logic                                       i_req_valid;
  logic                                       o_req_ready;
  logic [OPTN_ADDR_WIDTH-DC_OFFSET_WIDTH-1:0] i_req_addr;
  logic [OPTN_MHQ_TAG_WIDTH-1:0]              i_req_tag;

  logic                                       o_bus_en;
  logic [OPTN_ADDR_WIDTH-1:0]                 o_bus_addr;
  logic                                       i_bus_ack;
  logic [OPTN_BUS_DATA_WIDTH-1:0]             i_bus_data;

  logic                                       o_biu_done;
  logic [OPTN_MHQ_TAG_WIDTH-1:0]              o_biu_tag;
  logic [DC_LINE_WIDTH-1:0]                   o_biu_data;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_tag, i_bus_ack, i_bus_data,
    output o_req_ready, o_bus_en, o_bus_addr, o_biu_done, o_biu_tag, o_biu_data
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_tag, i_bus_ack, i_bus_data,
    input  o_req_ready, o_bus_en, o_bus_addr, o_biu_done, o_biu_tag, o_biu_data
  );

endinterface

// File: rtl/procyon_biu_line_fetch_beat_assembler.sv
// Beat counter plus line register: each accepted beat is written into the
// slot selected by the counter, beat 0 landing at the line LSBs.
module procyon_biu_beat_assembler
  import procyon_biu_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int BEATS     = 8,
  parameter int CNT_WIDTH = biu_cnt_width(BEATS)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_en,
  input  logic                       i_clear,
  input  logic [BUS_WIDTH-1:0]       i_data,
  output logic [BUS_WIDTH*BEATS-1:0] o_line,
  output logic [CNT_WIDTH-1:0]       o_beat_cnt,
  output logic                       o_last_beat
);

  logic [CNT_WIDTH-1:0] cnt_next;

  // BEATS is a power of two, so the increment wraps to zero after the last beat.
  assign cnt_next    = i_clear ? '0 : o_beat_cnt + CNT_WIDTH'(1);
  assign o_last_beat = (o_beat_cnt == CNT_WIDTH'(BEATS - 1));

  procyon_srff #(.WIDTH(CNT_WIDTH), .RESET_VALUE('0)) u_beat_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .i_en  (i_en | i_clear),
    .i_d   (cnt_next),
    .o_q   (o_beat_cnt)
  );

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    procyon_ff #(.WIDTH(BUS_WIDTH)) u_beat_data (
      .clk  (clk),
      .i_en (i_en && (o_beat_cnt == CNT_WIDTH'(b))),
      .i_d  (i_data),
      .o_q  (o_line[b*BUS_WIDTH +: BUS_WIDTH])
    );
  end

endmodule

// File: rtl/procyon_ff.sv
// Enabled datapath register with no reset.
module procyon_ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // NOTE: datapath storage is deliberately left unreset; its contents are
  // only consumed after being written, and skipping the reset keeps the
  // reset net off wide data registers.
  always_ff @(posedge clk) begin
    if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/procyon_srff.sv
// Enabled control register with asynchronous active-low reset to a constant.
module procyon_srff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    o_q <= RESET_VALUE;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/procyon_biu_line_fetch.sv
// Line-fill engine: takes one MHQ miss, reads the line as ascending bus
// beats, then reports the assembled line with a one-cycle done pulse.
module procyon_biu_line_fetch
  import procyon_biu_pkg::*;
#(
  parameter int OPTN_ADDR_WIDTH     = 32,
  parameter int OPTN_DC_LINE_SIZE   = 32,
  parameter int OPTN_BUS_DATA_WIDTH = 32,
  parameter int OPTN_MHQ_TAG_WIDTH  = 2
) (
  input logic                     clk,
  input logic                     n_rst,
  procyon_biu_line_fetch_if.slave bus
);

  localparam int DC_LINE_WIDTH   = OPTN_DC_LINE_SIZE * 8;
  localparam int DC_OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE);
  localparam int LINE_ADDR_WIDTH = OPTN_ADDR_WIDTH - DC_OFFSET_WIDTH;
  localparam int BEATS           = DC_LINE_WIDTH / OPTN_BUS_DATA_WIDTH;
  localparam int CNT_WIDTH       = biu_cnt_width(BEATS);
  localparam int BYTE_SEL_WIDTH  = biu_byte_sel_width(OPTN_BUS_DATA_WIDTH);

  logic [BIU_STATE_WIDTH-1:0]    state_q;
  biu_state_e                    state;
  biu_state_e                    state_next;
  logic                          accept;
  logic                          beat_en;
  logic                          last_beat;
  logic [CNT_WIDTH-1:0]          beat_cnt;
  logic [DC_OFFSET_WIDTH-1:0]    beat_offset;
  logic [LINE_ADDR_WIDTH-1:0]    addr_r;
  logic [OPTN_MHQ_TAG_WIDTH-1:0] tag_r;
  logic [DC_LINE_WIDTH-1:0]      line;

  assign state   = biu_state_e'(state_q);
  assign accept  = (state == BIU_STATE_IDLE) && bus.i_req_valid;
  assign beat_en = (state == BIU_STATE_BUSY) && bus.i_bus_ack;

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = BIU_STATE_IDLE;
    case (state)
      BIU_STATE_IDLE: state_next = bus.i_req_valid ? BIU_STATE_BUSY : BIU_STATE_IDLE;
      BIU_STATE_BUSY: state_next = (bus.i_bus_ack && last_beat) ? BIU_STATE_DONE : BIU_STATE_BUSY;
      BIU_STATE_DONE: state_next = BIU_STATE_IDLE;
      default:        state_next = BIU_STATE_IDLE;
    endcase
  end

  procyon_srff #(.WIDTH(BIU_STATE_WIDTH), .RESET_VALUE(BIU_STATE_IDLE)) u_state (
    .clk   (clk),
    .n_rst (n_rst),
    .i_en  (1'b1),
    .i_d   (state_next),
    .o_q   (state_q)
  );

  procyon_ff #(.WIDTH(LINE_ADDR_WIDTH)) u_addr (
    .clk  (clk),
    .i_en (accept),
    .i_d  (bus.i_req_addr),
    .o_q  (addr_r)
  );

  procyon_ff #(.WIDTH(OPTN_MHQ_TAG_WIDTH)) u_tag (
    .clk  (clk),
    .i_en (accept),
    .i_d  (bus.i_req_tag),
    .o_q  (tag_r)
  );

  procyon_biu_beat_assembler #(
    .BUS_WIDTH (OPTN_BUS_DATA_WIDTH),
    .BEATS     (BEATS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_assembler (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_en        (beat_en),
    .i_clear     (accept),
    .i_data      (bus.i_bus_data),
    .o_line      (line),
    .o_beat_cnt  (beat_cnt),
    .o_last_beat (last_beat)
  );

  // Beat index sits directly above the byte-select bits inside the line offset.
  assign beat_offset = DC_OFFSET_WIDTH'(beat_cnt) << BYTE_SEL_WIDTH;

  // All outputs decode the registered state; ack never reaches them combinationally.
  assign bus.o_req_ready = (state == BIU_STATE_IDLE);
  assign bus.o_bus_en    = (state == BIU_STATE_BUSY);
  assign bus.o_bus_addr  = {addr_r, beat_offset};
  assign bus.o_biu_done  = (state == BIU_STATE_DONE);
  assign bus.o_biu_tag   = tag_r;
  assign bus.o_biu_data  = line;

endmodule
